// File: rtl/qupls_alu_rsv_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_alu_rsv_queue_pkg
//  Description : Shared types for the multi-entry ALU reservation queue.
//  Revision    : 1.0  initial release
// ============================================================================
package qupls_alu_rsv_queue_pkg;

    localparam int c_WID   = 64;
    localparam int c_NOPS  = 3;
    localparam int c_PREGW = 9;
    localparam int c_ROBW  = 6;
    localparam int c_CPW   = 3;
    localparam int c_INSW  = 48;

    typedef logic [c_WID-1:0]   value_t;
    typedef logic [c_PREGW-1:0] pregno_t;
    typedef logic [c_ROBW-1:0]  rob_ndx_t;
    typedef logic [c_CPW-1:0]   checkpt_ndx_t;
    typedef logic [c_INSW-1:0]  ex_instruction_t;

    localparam logic [6:0]      OP_NOP    = 7'h0B;
    localparam ex_instruction_t c_NOP_INS = {41'd0, OP_NOP};

    // One queue slot: captured operands, their tags and readiness.
    typedef struct packed {
        logic                        v;
        rob_ndx_t                    id;
        checkpt_ndx_t                cp;
        ex_instruction_t             op;
        pregno_t [c_NOPS-1:0]        tag;
        value_t  [c_NOPS-1:0]        val;
        logic    [c_NOPS-1:0]        rdy;
        logic    [2*c_NOPS-1:0]      mod;
        value_t                      imm;
        logic                        cpytgt;
    } rsq_entry_t;

    // Operand modifier {inv,neg}: 01 negates, 11 inverts, otherwise pass.
    function automatic value_t apply_mod(input value_t x, input logic [1:0] m);
        case (m)
            2'b01:   apply_mod = -x;
            2'b11:   apply_mod = ~x;
            default: apply_mod = x;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/qupls_alu_rsv_queue_age_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_alu_rsv_queue_age_matrix
//  Description : Age matrix; each row lists the entries older than that row.
//                Grants the oldest requester.
//  Revision    : 1.0  initial release
// ============================================================================
module qupls_alu_rsv_queue_age_matrix #(
    parameter int NENTRY = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NENTRY-1:0] alloc,
    input  logic [NENTRY-1:0] free,
    input  logic [NENTRY-1:0] valid,
    input  logic [NENTRY-1:0] req,
    output logic [NENTRY-1:0] grant
);

    logic [NENTRY-1:0] r_older [NENTRY];

    // On allocation the new row records every surviving entry as older;
    // freed entries drop out of all rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NENTRY; i++)
                r_older[i] <= '0;
        end else begin
            for (int i = 0; i < NENTRY; i++) begin
                if (alloc[i])
                    r_older[i] <= valid & ~free;
                else
                    r_older[i] <= r_older[i] & ~free;
            end
        end
    end

    // A requester wins when no older entry is also requesting.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NENTRY; i++)
            grant[i] = req[i] & ~|(r_older[i] & req);
    end

endmodule
`default_nettype wire

// File: rtl/qupls_alu_rsv_queue.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_alu_rsv_queue
//  Description : Multi-entry ALU reservation station with operand wakeup,
//                oldest-ready select, registered issue port and checkpoint
//                squash.
//  Revision    : 1.0  initial release
// ============================================================================
module qupls_alu_rsv_queue
    import qupls_alu_rsv_queue_pkg::*;
#(
    parameter int NENTRY = 4,
    parameter int NOPS   = c_NOPS,
    parameter int NWAKE  = 4,
    parameter int WID    = c_WID
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         disp_v,
    output logic                         disp_rdy,
    input  logic [c_ROBW-1:0]            disp_id,
    input  logic [c_CPW-1:0]             disp_cp,
    input  logic [c_INSW-1:0]            disp_op,
    input  logic [NOPS*c_PREGW-1:0]      disp_tag,
    input  logic [NOPS*WID-1:0]          disp_val,
    input  logic [NOPS-1:0]              disp_vld,
    input  logic [2*NOPS-1:0]            disp_mod,
    input  logic [WID-1:0]               disp_imm,
    input  logic                         disp_cpytgt,
    input  logic [NWAKE-1:0]             wk_v,
    input  logic [NWAKE*c_PREGW-1:0]     wk_tag,
    input  logic [NWAKE*WID-1:0]         wk_val,
    input  logic                         flush_v,
    input  logic [c_CPW-1:0]             flush_cp,
    output logic                         iss_v,
    input  logic                         iss_rdy,
    output logic [c_ROBW-1:0]            iss_id,
    output logic [c_CPW-1:0]             iss_cp,
    output logic [c_INSW-1:0]            iss_op,
    output logic [NOPS*WID-1:0]          iss_arg,
    output logic [WID-1:0]               iss_imm,
    output logic                         iss_cpytgt,
    output logic [$clog2(NENTRY+1)-1:0]  count
);

    localparam int                c_CNTW = $clog2(NENTRY+1);
    localparam logic [c_CNTW-1:0] c_FULL = c_CNTW'(NENTRY);

    rsq_entry_t        r_ent     [NENTRY];
    rsq_entry_t        w_ent_nxt [NENTRY];
    rsq_entry_t        w_disp_ent;
    rsq_entry_t        w_sel;
    logic              w_sel_v;
    logic [NENTRY-1:0] w_vld, w_req, w_grant, w_alloc, w_free, w_flush_hit;
    logic              w_load, w_disp_take, w_out_flush;
    logic [c_CNTW-1:0] r_count, w_count_nxt;

    logic                r_iss_v;
    rob_ndx_t            r_iss_id;
    checkpt_ndx_t        r_iss_cp;
    ex_instruction_t     r_iss_op;
    logic [NOPS*WID-1:0] r_iss_arg;
    value_t              r_iss_imm;
    logic                r_iss_cpytgt;

    assign disp_rdy    = (r_count < c_FULL);
    assign w_load      = ~r_iss_v | iss_rdy;
    assign w_disp_take = disp_v & disp_rdy & ~(flush_v & (disp_cp == flush_cp));
    assign w_out_flush = r_iss_v & flush_v & (r_iss_cp == flush_cp);
    assign w_free      = w_flush_hit | (w_grant & {NENTRY{w_load}});

    // Ready requests use start-of-cycle readiness; squashed entries never compete.
    always_comb begin
        w_vld       = '0;
        w_req       = '0;
        w_flush_hit = '0;
        for (int i = 0; i < NENTRY; i++) begin
            w_vld[i]       = r_ent[i].v;
            w_flush_hit[i] = r_ent[i].v & flush_v & (r_ent[i].cp == flush_cp);
            w_req[i]       = r_ent[i].v & (&r_ent[i].rdy) & ~w_flush_hit[i];
        end
    end

    // Lowest-index free slot receives the dispatched op.
    always_comb begin
        w_alloc = '0;
        for (int i = NENTRY-1; i >= 0; i--) begin
            if (!r_ent[i].v) begin
                w_alloc    = '0;
                w_alloc[i] = w_disp_take;
            end
        end
    end

    // Build the incoming entry, catching a result broadcast in the same cycle.
    always_comb begin
        w_disp_ent        = '0;
        w_disp_ent.v      = 1'b1;
        w_disp_ent.id     = disp_id;
        w_disp_ent.cp     = disp_cp;
        w_disp_ent.op     = disp_op;
        w_disp_ent.mod    = disp_mod;
        w_disp_ent.imm    = disp_imm;
        w_disp_ent.cpytgt = disp_cpytgt;
        for (int k = 0; k < NOPS; k++) begin
            w_disp_ent.tag[k] = disp_tag[k*c_PREGW +: c_PREGW];
            w_disp_ent.val[k] = disp_val[k*WID +: WID];
            w_disp_ent.rdy[k] = disp_vld[k];
            if (!disp_vld[k]) begin
                // Descending scan so the lowest bus index has the last word.
                for (int b = NWAKE-1; b >= 0; b--) begin
                    if (wk_v[b] && (wk_tag[b*c_PREGW +: c_PREGW] == w_disp_ent.tag[k])) begin
                        w_disp_ent.rdy[k] = 1'b1;
                        w_disp_ent.val[k] = wk_val[b*WID +: WID];
                    end
                end
            end
        end
    end

    // Next slot contents: operand capture, release, then allocation.
    always_comb begin
        for (int i = 0; i < NENTRY; i++) begin
            w_ent_nxt[i] = r_ent[i];
            for (int k = 0; k < NOPS; k++) begin
                for (int b = NWAKE-1; b >= 0; b--) begin
                    if (!r_ent[i].rdy[k] && wk_v[b] &&
                        (wk_tag[b*c_PREGW +: c_PREGW] == r_ent[i].tag[k])) begin
                        w_ent_nxt[i].rdy[k] = 1'b1;
                        w_ent_nxt[i].val[k] = wk_val[b*WID +: WID];
                    end
                end
            end
            if (w_free[i])
                w_ent_nxt[i].v = 1'b0;
            if (w_alloc[i])
                w_ent_nxt[i] = w_disp_ent;
        end
    end

    // Occupancy after this edge and the one-hot grant turned into a payload.
    always_comb begin
        w_count_nxt = '0;
        w_sel       = '0;
        w_sel_v     = |w_grant;
        for (int i = 0; i < NENTRY; i++) begin
            w_count_nxt = w_count_nxt + {{(c_CNTW-1){1'b0}}, w_ent_nxt[i].v};
            if (w_grant[i])
                w_sel = r_ent[i];
        end
    end

    // Slot storage and occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NENTRY; i++)
                r_ent[i] <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < NENTRY; i++)
                r_ent[i] <= w_ent_nxt[i];
            r_count <= w_count_nxt;
        end
    end

    // Issue register: refills whenever empty or drained; squash beats a held op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iss_v      <= 1'b0;
            r_iss_id     <= '0;
            r_iss_cp     <= '0;
            r_iss_op     <= c_NOP_INS;
            r_iss_arg    <= '0;
            r_iss_imm    <= '0;
            r_iss_cpytgt <= 1'b0;
        end else if (w_load) begin
            r_iss_v <= w_sel_v;
            if (w_sel_v) begin
                r_iss_id     <= w_sel.id;
                r_iss_cp     <= w_sel.cp;
                r_iss_op     <= w_sel.cpytgt ? c_NOP_INS : w_sel.op;
                r_iss_imm    <= w_sel.imm;
                r_iss_cpytgt <= w_sel.cpytgt;
                for (int k = 0; k < NOPS; k++)
                    r_iss_arg[k*WID +: WID] <= apply_mod(w_sel.val[k], w_sel.mod[2*k +: 2]);
            end
        end else if (w_out_flush) begin
            r_iss_v <= 1'b0;
        end
    end

    qupls_alu_rsv_queue_age_matrix #(
        .NENTRY (NENTRY)
    ) u_age (
        .clk   (clk),
        .rst   (rst),
        .alloc (w_alloc),
        .free  (w_free),
        .valid (w_vld),
        .req   (w_req),
        .grant (w_grant)
    );

    assign iss_v      = r_iss_v;
    assign iss_id     = r_iss_id;
    assign iss_cp     = r_iss_cp;
    assign iss_op     = r_iss_op;
    assign iss_arg    = r_iss_arg;
    assign iss_imm    = r_iss_imm;
    assign iss_cpytgt = r_iss_cpytgt;
    assign count      = r_count;

endmodule
`default_nettype wire
